// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: pointer/depth derivation and UART status-register bit indices
// shared by the FIFO controller and the register block.
package uart_fifo_pkg;
   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_AFULL = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_UNF   = 4;
   function automatic int fifo_depth(input int addrsize);
      return 1 << addrsize;
   endfunction
   // One extra pointer bit separates full from empty when the low bits match.
   function automatic int ptr_width(input int addrsize);
      return addrsize + 1;
   endfunction
endpackage

// File: rtl/uart_fifo_ptr.sv
// uart_fifo_ptr: FIFO pointer counter with enable and async reset; the MSB
// toggles on every wrap of the low address bits.
module uart_fifo_ptr #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   output logic [W-1:0] o_ptr
);
   logic [W-1:0] r_ptr;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_ptr <= '0;
      else if (i_en) r_ptr <= r_ptr + 1'b1;
   assign o_ptr = r_ptr;
endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: single-clock FIFO controller driving an external fifomem RAM.
// Optional high-water mark output enabled by defining UART_FIFO_PEAK_EN.
module uart_fifo_ctrl
   import uart_fifo_pkg::*;
#(
   parameter int DATASIZE  = 8,
   parameter int ADDRSIZE  = 4,
   parameter int AFULL_LVL = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_req,
   input  logic [DATASIZE-1:0] wr_data,
   input  logic                rd_req,
   output logic [DATASIZE-1:0] rd_data,
   output logic                rd_valid,
   output logic                full,
   output logic                empty,
   output logic                almost_full,
   output logic [ADDRSIZE:0]   count,
   output logic                overflow,
   output logic                underflow,
   input  logic                err_clr,
`ifdef UART_FIFO_PEAK_EN
   output logic [ADDRSIZE:0]   peak,
`endif
   output logic [ADDRSIZE-1:0] mem_waddr,
   output logic [ADDRSIZE-1:0] mem_raddr,
   output logic [DATASIZE-1:0] mem_wdata,
   output logic                mem_wclken,
   input  logic [DATASIZE-1:0] mem_rdata
);
   localparam int PW = ptr_width(ADDRSIZE);
   localparam logic [PW-1:0] AF = PW'(AFULL_LVL);
   logic [PW-1:0]       w_wptr, w_rptr;
   logic                w_push_ok, w_pop_ok;
   logic [DATASIZE-1:0] r_rd_data;
   logic                r_rd_valid, r_ovf, r_unf;
   uart_fifo_ptr #(.W(PW)) u_wptr (.clk(clk), .rst(rst), .i_en(w_push_ok), .o_ptr(w_wptr));
   uart_fifo_ptr #(.W(PW)) u_rptr (.clk(clk), .rst(rst), .i_en(w_pop_ok),  .o_ptr(w_rptr));
   assign empty       = w_wptr == w_rptr;
   assign full        = (w_wptr[PW-1] != w_rptr[PW-1]) && (w_wptr[ADDRSIZE-1:0] == w_rptr[ADDRSIZE-1:0]);
   assign count       = w_wptr - w_rptr;
   assign almost_full = count >= AF;
   // A pop frees a slot on the same edge, so a full FIFO still takes a push alongside it.
   assign w_pop_ok    = rd_req & ~empty;
   assign w_push_ok   = wr_req & (~full | w_pop_ok);
   assign mem_waddr   = w_wptr[ADDRSIZE-1:0];
   assign mem_raddr   = w_rptr[ADDRSIZE-1:0];
   assign mem_wdata   = wr_data;
   assign mem_wclken  = w_push_ok;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else begin
         if (w_pop_ok) r_rd_data <= mem_rdata;
         r_rd_valid <= w_pop_ok;
         r_ovf      <= (wr_req & ~w_push_ok) | (r_ovf & ~err_clr);
         r_unf      <= (rd_req & ~w_pop_ok) | (r_unf & ~err_clr);
      end
   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
`ifdef UART_FIFO_PEAK_EN
   logic [ADDRSIZE:0] r_peak;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_peak <= '0;
      else r_peak <= (err_clr || count > r_peak) ? count : r_peak;
   assign peak = r_peak;
`endif
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: scoreboard bench for uart_fifo_ctrl with a behavioural
// combinational-read RAM standing in for fifomem.
module tb_uart_fifo_ctrl;
   logic       clk = 1'b0;
   logic       rst, wr_req, rd_req, err_clr;
   logic [7:0] wr_data, rd_data, mem_wdata, mem_rdata;
   logic       rd_valid, full, empty, almost_full, overflow, underflow, mem_wclken;
   logic [4:0] count;
   logic [3:0] mem_waddr, mem_raddr;
`ifdef UART_FIFO_PEAK_EN
   logic [4:0] peak;
`endif
   logic [7:0] mem [16];
   logic [7:0] m_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] m_rd;
   logic       m_ovf, m_unf;
   int         m_peak;
   int         n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
   always @(posedge clk) if (mem_wclken) mem[mem_waddr] <= mem_wdata;
   assign mem_rdata = mem[mem_raddr];
   uart_fifo_ctrl dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow),
      .err_clr(err_clr),
`ifdef UART_FIFO_PEAK_EN
      .peak(peak),
`endif
      .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
      .mem_wclken(mem_wclken), .mem_rdata(mem_rdata));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_rd = 8'h00;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_peak = 0;
   endtask
   task automatic check_status();
      chk("count", 32'(count), 32'(m_q.size()));
      chk("full", 32'(full), 32'(m_q.size() == 16));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(m_q.size() >= 12));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef UART_FIFO_PEAK_EN
      chk("peak", 32'(peak), 32'(m_peak));
`endif
   endtask
   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
      int  n;
      bit  pop, push;
      wr_req = w; wr_data = d; rd_req = r; err_clr = c;
      n = m_q.size();
      pop = r && n > 0;
      push = w && (n < 16 || pop);
      if (pop) exp_q.push_back(m_q.pop_front());
      if (push) m_q.push_back(d);
      m_ovf = (w && !push) || (m_ovf && !c);
      m_unf = (r && !pop) || (m_unf && !c);
      m_peak = (c || n > m_peak) ? n : m_peak;
      @(posedge clk); #1;
      chk("rd_valid", 32'(rd_valid), 32'(pop));
      if (rd_valid && exp_q.size() > 0) m_rd = exp_q.pop_front();
      chk("rd_data", 32'(rd_data), 32'(m_rd));
      check_status();
   endtask
   initial begin
      rst = 1'b1; wr_req = 0; rd_req = 0; err_clr = 0; wr_data = 0;
      model_reset();
      #1;
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      check_status();
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
      for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0);
      cyc(1, 8'hAA, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(1, 8'h55, 1, 0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
      cyc(1, 8'h33, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 40; i++)
         cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1, 0);
      while (m_q.size() > 0) cyc(0, 0, 1, 0);
      for (int i = 0; i < 7; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
      wr_req = 0; rd_req = 1;
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("arst_empty", 32'(empty), 1);
      chk("arst_count", 32'(count), 0);
      chk("arst_rd_valid", 32'(rd_valid), 0);
`ifdef UART_FIFO_PEAK_EN
      chk("arst_peak", 32'(peak), 0);
`endif
      rd_req = 0;
      @(posedge clk); #1 rst = 1'b0;
      cyc(1, 8'h77, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
